// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC decimator front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cic_pkg;

  localparam int CIC_IN_W  = 14;
  localparam int CIC_OUT_W = 18;
  localparam int CIC_R     = 16;
  localparam int CIC_N     = 3;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Accumulator width needed for full CIC bit growth: IN_W + N*log2(R).
  function automatic int cic_acc_w(input int in_w, input int r, input int n);
    return in_w + n * clog2(r);
  endfunction

endpackage

// File: rtl/cic_out_hold.sv
// One-entry hold buffer feeding the FIR nd/rfd handshake, with sticky overwrite flag.
// Latency: 1 cycle from load to nd when rfd is high and nothing is pending.
// Backpressure: holds one sample while rfd=0; a further load overwrites it and sets ovf.
module cic_out_hold
  import cic_pkg::*;
#(
  parameter int W = CIC_OUT_W
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         load_vld_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         rfd_i,
  output logic [W-1:0] dout_o,
  output logic         nd_o,
  output logic         ovf_o
);

  logic [W-1:0] hold_q, hold_d;
  logic         pending_q, pending_d;
  logic [W-1:0] dout_q, dout_d;
  logic         nd_q, nd_d;
  logic         ovf_q, ovf_d;
  logic         drain;

  assign drain = pending_q & rfd_i;

  // Delivery and load rules; a load in the same cycle as a drain keeps pending set.
  always_comb begin
    hold_d    = hold_q;
    pending_d = pending_q;
    dout_d    = dout_q;
    nd_d      = 1'b0;
    ovf_d     = ovf_q;
    if (drain) begin
      dout_d    = hold_q;
      nd_d      = 1'b1;
      pending_d = 1'b0;
    end
    if (load_vld_i) begin
      hold_d    = load_dat_i;
      pending_d = 1'b1;
      if (pending_q && !rfd_i) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (sclr) begin
      hold_q    <= '0;
      pending_q <= 1'b0;
      dout_q    <= '0;
      nd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      pending_q <= pending_d;
      dout_q    <= dout_d;
      nd_q      <= nd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign dout_o = dout_q;
  assign nd_o   = nd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/cic_decim_front.sv
// N-stage CIC decimate-by-R ahead of the first FIR, output sliced to the FIR input width.
// Latency: decimation tick -> N comb registers -> hold load -> nd (N+2 edges after the tick).
// Backpressure: FIR rfd stalls delivery only; the CIC keeps running and overwrites are flagged.
module cic_decim_front
  import cic_pkg::*;
#(
  parameter int IN_W  = CIC_IN_W,
  parameter int OUT_W = CIC_OUT_W,
  parameter int R     = CIC_R,
  parameter int N     = CIC_N
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [IN_W-1:0]  din,
  input  logic             din_vld,
  input  logic             rfd,
  output logic [OUT_W-1:0] dout,
  output logic             nd,
  output logic             ovf
);

  localparam int ACC_W = cic_acc_w(IN_W, R, N);
  localparam int CNT_W = (clog2(R) < 1) ? 1 : clog2(R);

  logic [ACC_W-1:0] din_ext;
  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

  // Integrators: each stage adds the previous stage's registered value (pipelined form).
  for (genvar k = 1; k <= N; k++) begin : g_int
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    if (k == 1) begin : g_first
      assign acc_d = acc_q + din_ext;
    end else begin : g_rest
      assign acc_d = acc_q + g_int[k-1].acc_q;
    end
    // Accumulate only on valid input-rate samples; wrap-around is intended.
    always_ff @(posedge clk) begin
      if (sclr) begin
        acc_q <= '0;
      end else if (din_vld) begin
        acc_q <= acc_d;
      end
    end
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_tick;

  assign dec_tick = din_vld && (cnt_q == CNT_W'(R - 1));
  assign cnt_d    = dec_tick ? '0 : (cnt_q + CNT_W'(1));

  // Decimation counter advances once per valid input sample.
  always_ff @(posedge clk) begin
    if (sclr) begin
      cnt_q <= '0;
    end else if (din_vld) begin
      cnt_q <= cnt_d;
    end
  end

  logic [ACC_W-1:0] samp_q;
  logic             samp_vld_q;

  // Capture the last integrator including this cycle's update, so no extra input slips in.
  always_ff @(posedge clk) begin
    if (sclr) begin
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
    end else begin
      samp_vld_q <= dec_tick;
      if (dec_tick) begin
        samp_q <= g_int[N].acc_d;
      end
    end
  end

  // Combs with differential delay 1; each stage registers once per decimated sample.
  for (genvar k = 1; k <= N; k++) begin : g_comb
    logic [ACC_W-1:0] x_in;
    logic             v_in;
    logic [ACC_W-1:0] c_q;
    logic [ACC_W-1:0] dly_q;
    logic             v_q;
    if (k == 1) begin : g_first
      assign x_in = samp_q;
      assign v_in = samp_vld_q;
    end else begin : g_rest
      assign x_in = g_comb[k-1].c_q;
      assign v_in = g_comb[k-1].v_q;
    end
    // Difference against the previous decimated sample; the valid bit rides along.
    always_ff @(posedge clk) begin
      if (sclr) begin
        c_q   <= '0;
        dly_q <= '0;
        v_q   <= 1'b0;
      end else begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= x_in - dly_q;
          dly_q <= x_in;
        end
      end
    end
  end

  // Top OUT_W bits: plain truncation, DC gain R^N lands the input at full scale.
  logic [OUT_W-1:0] comb_out;
  assign comb_out = g_comb[N].c_q[ACC_W-1 -: OUT_W];

  cic_out_hold #(
    .W (OUT_W)
  ) u_hold (
    .clk        (clk),
    .sclr       (sclr),
    .load_vld_i (g_comb[N].v_q),
    .load_dat_i (comb_out),
    .rfd_i      (rfd),
    .dout_o     (dout),
    .nd_o       (nd),
    .ovf_o      (ovf)
  );

endmodule

// File: tb/tb_cic_decim_front.sv
module tb_cic_decim_front;

  localparam int IN_W  = 14;
  localparam int OUT_W = 18;

  logic             clk = 1'b0;
  logic             sclr;
  logic [IN_W-1:0]  din;
  logic             din_vld;
  logic             rfd;
  logic [OUT_W-1:0] dout;
  logic             nd;
  logic             ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_decim_front dut (
    .clk     (clk),
    .sclr    (sclr),
    .din     (din),
    .din_vld (din_vld),
    .rfd     (rfd),
    .dout    (dout),
    .nd      (nd),
    .ovf     (ovf)
  );

  logic [OUT_W-1:0] exp_q[$];
  int nd_cnt   = 0;
  int gap_exp  = 0;
  int seg      = 0;
  int seg_seen = -1;
  int last_cyc = 0;
  bit sparse   = 1'b0;
  int sp_cnt   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int v);
    logic [OUT_W-1:0] s;
    s = v[OUT_W-1:0];
    exp_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sparse) begin
      sp_cnt++;
      din_vld = (sp_cnt % 3 == 0);
    end
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    tick();
    tick();
    sclr = 1'b0;
    seg++;
  endtask

  task automatic wait_cnt(input string name, input int target, input int budget);
    for (int i = 0; i < budget && nd_cnt < target; i++) tick();
    chk(name, (nd_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_nd(input string name, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      tick();
      if (nd) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    sclr    = 1'b1;
    din     = 14'd100;
    din_vld = 1'b1;
    rfd     = 1'b1;
    fork
      begin : driver
        // Reset then DC 100: transients 218, 1281, then 1600 every 16 cycles.
        do_reset();
        chk("rst_dout", int'(dout), 0);
        chk("rst_nd", int'(nd), 0);
        chk("rst_ovf", int'(ovf), 0);
        push_exp(218); push_exp(1281);
        for (int i = 0; i < 4; i++) push_exp(1600);
        gap_exp = 16;
        wait_cnt("dc_outputs", 6, 200);
        chk("dc_queue_empty", exp_q.size(), 0);
        chk("dc_ovf", int'(ovf), 0);

        // Backpressure spanning exactly one hold load.
        gap_exp = 0;
        push_exp(1600);
        wait_nd("bp_sync_nd", 40);
        repeat (10) tick();
        rfd = 1'b0;
        push_exp(1600);
        begin
          int n0;
          n0 = nd_cnt;
          repeat (10) tick();
          chk("bp_no_nd_while_stalled", nd_cnt, n0);
          rfd = 1'b1;
          tick();
          chk("bp_nd_after_release", int'(nd), 1);
          tick();
          chk("bp_single_nd", nd_cnt, n0 + 1);
          chk("bp_ovf", int'(ovf), 0);
        end

        // Overflow: two loads while stalled; release delivers one (newest) sample.
        push_exp(1600);
        wait_nd("ovf_sync_nd", 40);
        rfd = 1'b0;
        begin
          int n0;
          repeat (20) tick();
          n0 = nd_cnt;
          chk("ovf_clear_one_pending", int'(ovf), 0);
          repeat (20) tick();
          chk("ovf_set", int'(ovf), 1);
          chk("ovf_no_nd_while_stalled", nd_cnt, n0);
          push_exp(1600);
          rfd = 1'b1;
          tick();
          chk("ovf_release_nd", int'(nd), 1);
          tick();
          chk("ovf_nd_one_cycle", int'(nd), 0);
          chk("ovf_single_nd", nd_cnt, n0 + 1);
          push_exp(1600); push_exp(1600);
          wait_cnt("ovf_resume", n0 + 3, 60);
          chk("ovf_sticky", int'(ovf), 1);
        end

        // Mid-run reset while the comb pipeline holds a sample.
        push_exp(1600);
        wait_nd("mr_sync_nd", 40);
        repeat (11) tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        seg++;
        chk("mr_dout_zero", int'(dout), 0);
        chk("mr_nd_zero", int'(nd), 0);
        chk("mr_ovf_zero", int'(ovf), 0);
        begin
          int n0;
          n0 = nd_cnt;
          repeat (16) tick();
          chk("mr_no_nd_16_inputs", nd_cnt, n0);
          push_exp(218); push_exp(1281); push_exp(1600); push_exp(1600);
          gap_exp = 16;
          wait_cnt("mr_outputs", n0 + 4, 100);
          chk("mr_queue_empty", exp_q.size(), 0);
        end

        // Negative full scale: -8192 -> -131072 once settled.
        din = 14'h2000;
        do_reset();
        begin
          int n0;
          n0 = nd_cnt;
          push_exp(-17920); push_exp(-104960); push_exp(-131072); push_exp(-131072);
          wait_cnt("neg_outputs", n0 + 4, 120);
          chk("neg_queue_empty", exp_q.size(), 0);
        end

        // Sparse input: one valid every third cycle -> nd every 48 cycles.
        din    = 14'd100;
        sparse = 1'b1;
        sp_cnt = 0;
        gap_exp = 48;
        do_reset();
        begin
          int n0;
          n0 = nd_cnt;
          push_exp(218); push_exp(1281); push_exp(1600); push_exp(1600); push_exp(1600);
          wait_cnt("sparse_outputs", n0 + 5, 400);
          chk("sparse_queue_empty", exp_q.size(), 0);
          chk("sparse_ovf", int'(ovf), 0);
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (nd) begin
            nd_cnt++;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL nd_unexpected: got nd with dout=%0d, expected no sample (cycle %0d)",
                       $signed(dout), cyc);
            end else begin
              logic [OUT_W-1:0] e;
              e = exp_q.pop_front();
              chk("dout", int'($signed(dout)), int'($signed(e)));
            end
            if (gap_exp != 0 && seg_seen == seg) chk("nd_gap", cyc - last_cyc, gap_exp);
            last_cyc = cyc;
            seg_seen = seg;
          end
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
